// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-port memory bus arbiter between fetch and data ports
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   i_req, i_addr                 fetch request (read-only), held until i_ack
//   i_ack, i_rdata, i_stall       fetch completion pulse, fetched word, fetch waiting
//   d_req, d_we, d_addr,
//   d_wdata, d_sel                data request (load/store), held until d_ack
//   d_ack, d_rdata, d_stall       data completion pulse, load word (0 for stores), data waiting
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_sel            registered bus transaction fields
//   mem_ack, mem_rdata            slave completion and read data
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_sel,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_sel,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  state_t                state, state_nxt;
  logic [3:0]            starve_cnt, starve_nxt;
  logic                  mem_req_nxt, mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt;
  logic [3:0]            mem_sel_nxt;
  logic                  i_ack_nxt, d_ack_nxt;
  logic [DATA_WIDTH-1:0] i_rdata_nxt, d_rdata_nxt;
  logic                  i_elig, d_elig;

  // A port whose ack is high this cycle has just completed; its still-high
  // req must not win a second transaction.
  assign i_elig = i_req & ~i_ack;
  assign d_elig = d_req & ~d_ack;

  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_sel    <= 4'd0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      mem_sel    <= mem_sel_nxt;
      i_ack      <= i_ack_nxt;
      d_ack      <= d_ack_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    starve_nxt    = starve_cnt;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_sel_nxt   = mem_sel;
    // Acks are single-cycle pulses and read data is only non-zero alongside them.
    i_ack_nxt     = 1'b0;
    d_ack_nxt     = 1'b0;
    i_rdata_nxt   = '0;
    d_rdata_nxt   = '0;

    case (state)
      IDLE: begin
        // Data wins ties until the fetch port has been passed over
        // STARVE_LIMIT times in a row.
        if (d_elig && (!i_elig || (starve_cnt < STARVE_LIM))) begin
          state_nxt     = BUSY_D;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          mem_sel_nxt   = d_sel;
          if (i_elig && (starve_cnt != 4'hF)) begin
            starve_nxt = starve_cnt + 4'd1;
          end
        end else if (i_elig) begin
          state_nxt     = BUSY_I;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = i_addr;
          mem_wdata_nxt = '0;
          mem_sel_nxt   = 4'hF;
          starve_nxt    = 4'd0;
        end
      end

      BUSY_I: begin
        if (mem_ack) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          i_ack_nxt   = 1'b1;
          i_rdata_nxt = mem_rdata;
        end
      end

      BUSY_D: begin
        if (mem_ack) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          d_ack_nxt   = 1'b1;
          d_rdata_nxt = mem_we ? '0 : mem_rdata;
        end
      end

      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
      end
    endcase
  end

endmodule
